led_pattern_gen: RTL

Parametrised LED pattern generator, successor to the fixed 8-LED divided-clock counter. All logic runs on the single system clock; a prescaler produces a one-cycle tick enable, and no derived clocks are used. Four selectable display modes are cycled by a push button. The block sits directly under the board top and drives the LED pins.

---
 rtl/led_pattern_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 30 +++
 rtl/led_pattern_gen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: mode encoding and PWM counter width shared by the LED
// pattern generator and anything that decodes its mode_o output.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_BIN_UP = 2'd0,
        MODE_BIN_DN = 2'd1,
        MODE_GRAY   = 2'd2,
        MODE_SCAN   = 2'd3
    } mode_t;

    localparam int PWM_W = 4;

    // Modes cycle 0 -> 1 -> 2 -> 3 -> 0; the 2-bit add wraps naturally.
    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the system clock into a one-cycle enable pulse
// every DIV clocks. No derived clock is produced; consumers gate on tick.
module tick_prescaler #(
    parameter int DIV = 4194304
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int               CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Free-running count 0..DIV-1, wrapping back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // High for exactly the cycle in which the count sits at DIV-1.
    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: four-mode LED pattern generator (binary up, binary down,
// Gray code, bouncing scan) stepped by a prescaler tick, with the mode
// advanced by a synchronised push button.
// Optional build macro LED_PATTERN_PWM_EN adds a 4-bit PWM brightness gate
// on the LED outputs driven by the bright input.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int LED_W = 8,
    parameter int DIV   = 4194304
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_btn,
    input  logic             pause,
    input  logic [3:0]       bright,
    output logic [LED_W-1:0] led,
    output logic             tick,
    output logic [1:0]       mode_o
);

    localparam int               POS_W     = $clog2(LED_W);
    // Position from which an upward step lands on the top endpoint.
    localparam logic [POS_W-1:0] POS_TURN  = POS_W'(LED_W - 2);
    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

    logic             w_tick;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync2_d;
    logic             w_btn_rise;
    logic             w_step;

    mode_t            r_mode;
    mode_t            w_mode_nxt;
    logic [LED_W-1:0] r_count;
    logic [LED_W-1:0] w_count_nxt;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_pos_nxt;
    logic             r_dir_down;
    logic             w_dir_down_nxt;
    logic [LED_W-1:0] r_pattern;
    logic [LED_W-1:0] w_pattern_nxt;

    // LED image of a given state: count directly, its Gray code, or one-hot scan.
    function automatic logic [LED_W-1:0] pattern_of(
        input mode_t            m,
        input logic [LED_W-1:0] c,
        input logic [POS_W-1:0] p
    );
        case (m)
            MODE_GRAY: return c ^ (c >> 1);
            MODE_SCAN: return {{(LED_W-1){1'b0}}, 1'b1} << p;
            default:   return c;
        endcase
    endfunction

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Two-flop synchroniser plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_d <= 1'b0;
        end else begin
            r_sync1   <= mode_btn;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
        end
    end

    assign w_btn_rise = r_sync2 & ~r_sync2_d;
    // A mode change on the same edge swallows the tick.
    assign w_step     = w_tick & ~pause & ~w_btn_rise;
    assign w_mode_nxt = w_btn_rise ? next_mode(r_mode) : r_mode;

    // Next count / scan state: a mode change clears it, a step advances it.
    always_comb begin
        w_count_nxt    = r_count;
        w_pos_nxt      = r_pos;
        w_dir_down_nxt = r_dir_down;
        if (w_btn_rise) begin
            w_count_nxt    = '0;
            w_pos_nxt      = '0;
            w_dir_down_nxt = 1'b0;
        end else if (w_step) begin
            case (r_mode)
                MODE_BIN_UP, MODE_GRAY: w_count_nxt = r_count + LED_W'(1);
                MODE_BIN_DN:            w_count_nxt = r_count - LED_W'(1);
                MODE_SCAN: begin
                    if (!r_dir_down) begin
                        w_pos_nxt = r_pos + POS_ONE;
                        if (r_pos == POS_TURN) begin
                            w_dir_down_nxt = 1'b1;
                        end
                    end else begin
                        w_pos_nxt = r_pos - POS_ONE;
                        if (r_pos == POS_ONE) begin
                            w_dir_down_nxt = 1'b0;
                        end
                    end
                end
                default: w_count_nxt = r_count;
            endcase
        end
    end

    assign w_pattern_nxt = pattern_of(w_mode_nxt, w_count_nxt, w_pos_nxt);

    // Mode/pattern state machine; the pattern register tracks the state on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= MODE_BIN_UP;
            r_count    <= '0;
            r_pos      <= '0;
            r_dir_down <= 1'b0;
            r_pattern  <= '0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_count    <= w_count_nxt;
            r_pos      <= w_pos_nxt;
            r_dir_down <= w_dir_down_nxt;
            r_pattern  <= w_pattern_nxt;
        end
    end

`ifdef LED_PATTERN_PWM_EN
    logic [PWM_W-1:0] r_pwm_cnt;
    logic [PWM_W-1:0] w_pwm_nxt;
    logic             w_pwm_on;
    logic [LED_W-1:0] r_led;

    // Gate on the PWM value that will be current after this edge, so the
    // registered led matches pattern & (pwm_cnt < bright) in the same cycle.
    assign w_pwm_nxt = r_pwm_cnt + PWM_W'(1);
    assign w_pwm_on  = (w_pwm_nxt < bright);

    // Free-running PWM counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= w_pwm_nxt;
        end
    end

    // Registered LED drive: pattern masked by the PWM duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            r_led <= w_pattern_nxt & {LED_W{w_pwm_on}};
        end
    end

    assign led = r_led;
`else
    logic w_unused_bright;

    assign w_unused_bright = ^bright;
    assign led             = r_pattern;
`endif

    assign tick   = w_tick;
    assign mode_o = r_mode;

endmodule
